// File: rtl/fetch_pkg.sv
// Shared fetch-stage defaults and the control-priority encoding used by pc_unit.
package fetch_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int STEP_DEF      = 4;
    localparam int RESET_VEC_DEF = 0;

    typedef enum logic [1:0] {
        CTRL_SEQ      = 2'd0,
        CTRL_REDIRECT = 2'd1,
        CTRL_RET      = 2'd2,
        CTRL_CALL     = 2'd3
    } ctrl_e;

    // A mispredict (redirect) squashes call/ret, and ret wins over call.
    function automatic ctrl_e decode_ctrl(input logic redirect, input logic ret, input logic call);
        ctrl_e c;
        if (redirect) begin
            c = CTRL_REDIRECT;
        end else if (ret) begin
            c = CTRL_RET;
        end else if (call) begin
            c = CTRL_CALL;
        end else begin
            c = CTRL_SEQ;
        end
        return c;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is rejected; both error cases raise a registered one-cycle pulse.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         overflow_o,
    output logic         underflow_o
);
    import fetch_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty_s, full_s;

    assign empty_s     = (cnt_q == CNT_W'(0));
    assign full_s      = (cnt_q == CNT_W'(DEPTH));
    assign empty_o     = empty_s;
    assign full_o      = full_s;
    assign top_o       = mem_q[ptr_q - PTR_W'(1)];
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

    // Next pointer/count and error pulses; the pointer always names the next free slot.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (ce_i) begin
            if (push_i) begin
                ptr_d = ptr_q + PTR_W'(1);
                if (full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (pop_i) begin
                if (empty_s) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer, count and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_W'(0);
            cnt_q <= CNT_W'(0);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage; contents after reset are don't-care so no reset is applied.
    always_ff @(posedge clk) begin
        if (ce_i && push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirect, call/return via RAS,
// and alignment/stack status flags.
module pc_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                STEP       = STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF),
    parameter int                RAS_DEPTH  = 4,
    parameter int                ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              redirect,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              misaligned,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_underflow,
    output logic              ras_overflow
);

    localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_top_s;
    logic              push_s, pop_s;
    ctrl_e             ctrl_s;

    assign ctrl_s     = decode_ctrl(redirect, ret, call);
    assign push_s     = (ctrl_s == CTRL_CALL);
    assign pop_s      = (ctrl_s == CTRL_RET);
    assign pc         = pc_q;
    assign pc_plus    = pc_q + STEP_W;
    assign misaligned = |pc_q[ALIGN_BITS-1:0];

    ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce_i        (ce),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (pc_plus),
        .top_o       (ras_top_s),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    // Priority mux for the next PC; a ret on an empty stack falls through sequentially.
    always_comb begin
        pc_d = pc_q;
        if (ce) begin
            case (ctrl_s)
                CTRL_REDIRECT: pc_d = target;
                CTRL_RET:      pc_d = ras_empty ? pc_plus : ras_top_s;
                CTRL_CALL:     pc_d = target;
                CTRL_SEQ:      pc_d = pc_plus;
                default:       pc_d = pc_plus;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed test-plan steps followed by random control traffic, all checked
// against a queue-based return-address model.
module tb_pc_unit;

    localparam int          AW    = 32;
    localparam logic [31:0] RVEC  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        redirect = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] pc, pc_plus;
    logic        misaligned, ras_empty, ras_full, ras_underflow, ras_overflow;

    int checks = 0;
    int passes = 0;

    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    logic        m_uf, m_of;

    pc_unit #(
        .ADDR_W     (AW),
        .STEP       (4),
        .RESET_VEC  (RVEC),
        .RAS_DEPTH  (DEPTH),
        .ALIGN_BITS (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .redirect      (redirect),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .misaligned    (misaligned),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow),
        .ras_overflow  (ras_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = RVEC;
        m_stack.delete();
        m_uf = 1'b0;
        m_of = 1'b0;
    endtask

    // Apply one edge's worth of the behavioural rules to the model.
    task automatic model_step();
        m_uf = 1'b0;
        m_of = 1'b0;
        if (ce) begin
            if (redirect) begin
                m_pc = target;
            end else if (ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc = m_pc + 32'd4;
                    m_uf = 1'b1;
                end
            end else if (call) begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_of = 1'b1;
                end
                m_stack.push_back(m_pc + 32'd4);
                m_pc = target;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       pc,       m_pc);
        check({tag, ".pc_plus"},  pc_plus,  m_pc + 32'd4);
        check({tag, ".misalign"}, {31'd0, misaligned},    {31'd0, (m_pc[1:0] != 2'b00)});
        check({tag, ".empty"},    {31'd0, ras_empty},     {31'd0, (m_stack.size() == 0)});
        check({tag, ".full"},     {31'd0, ras_full},      {31'd0, (m_stack.size() == DEPTH)});
        check({tag, ".uflow"},    {31'd0, ras_underflow}, {31'd0, m_uf});
        check({tag, ".oflow"},    {31'd0, ras_overflow},  {31'd0, m_of});
    endtask

    // Drive controls at the falling edge, clock once, then compare just after the rising edge.
    task automatic cyc(input string tag, input logic c, input logic rd, input logic cl,
                       input logic rt, input logic [31:0] tg);
        @(negedge clk);
        ce = c; redirect = rd; call = cl; ret = rt; target = tg;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        check("reset.pc_lit", pc, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;

        cyc("seq1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc("seq2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc("seq3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("seq3.lit", pc, 32'h10C);
        cyc("hold1", 1'b0, 1'b1, 1'b0, 1'b0, 32'h5550);
        cyc("hold2", 1'b0, 1'b0, 1'b1, 1'b0, 32'h5550);
        check("hold.lit", pc, 32'h10C);

        cyc("redir_call", 1'b1, 1'b1, 1'b1, 1'b0, 32'h2000);
        check("redir_call.lit", pc, 32'h2000);
        check("redir_call.empty", {31'd0, ras_empty}, 32'd1);
        cyc("after_redir", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("after_redir.lit", pc, 32'h2004);

        cyc("to40",  1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
        cyc("call1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h800);
        cyc("seq800", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc("call2", 1'b1, 1'b0, 1'b1, 1'b0, 32'hC00);
        check("call2.lit", pc, 32'hC00);
        cyc("ret1",  1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ret1.lit", pc, 32'h808);
        cyc("ret2",  1'b1, 1'b0, 1'b1, 1'b1, 32'h9990);
        check("ret2.lit", pc, 32'h44);
        check("ret2.empty", {31'd0, ras_empty}, 32'd1);

        cyc("to10", 1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        for (int i = 1; i <= 5; i++) begin
            cyc($sformatf("ovcall%0d", i), 1'b1, 1'b0, 1'b1, 1'b0,
                (i == 5) ? 32'h900 : 32'(16 * (i + 1)));
        end
        check("ovcall5.oflow_lit", {31'd0, ras_overflow}, 32'd1);
        cyc("ov_seq", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("ov_seq.oflow_lit", {31'd0, ras_overflow}, 32'd0);
        cyc("ovret1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ovret1.lit", pc, 32'h54);
        cyc("ovret2", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ovret2.lit", pc, 32'h44);
        cyc("ovret3", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ovret3.lit", pc, 32'h34);
        cyc("ovret4", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ovret4.lit", pc, 32'h24);

        cyc("to60", 1'b1, 1'b1, 1'b0, 1'b0, 32'h60);
        cyc("uf",   1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("uf.lit", pc, 32'h64);
        check("uf.pulse_lit", {31'd0, ras_underflow}, 32'd1);
        cyc("uf_clear", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.lit", pc, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;

        cyc("toFFFC", 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        cyc("wrap",   1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap.lit", pc, 32'h0);
        cyc("mis",    1'b1, 1'b1, 1'b0, 1'b0, 32'h1002);
        check("mis.lit", {31'd0, misaligned}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom();
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8 | {28'd0, t[3:0]};
            cyc("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), t);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the fetch stage; generalises the 5-bit increment/load counter to ADDR_W bits with a configurable step and reset vector.
- Adds prioritised redirect, call/return support through an internal return-address stack (RAS), and error/status flags.
- Sits between branch resolution and instruction memory; `pc` drives the instruction memory address.

Parameters:
- ADDR_W, 32, PC width in bits.
- STEP, 4, sequential increment in bytes.
- RESET_VEC, 0, PC value after reset.
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.
- ALIGN_BITS, 2, low PC bits that must be zero for alignment.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes all state.
- redirect  in  1  load `target` (branch or jump taken).
- call  in  1  push `pc+STEP`, load `target`.
- ret  in  1  pop RAS top into PC.
- target  in  ADDR_W  redirect/call destination.
- pc  out  ADDR_W  current PC (registered).
- pc_plus  out  ADDR_W  `pc+STEP`, combinational, modulo 2^ADDR_W.
- misaligned  out  1  combinational; high when `pc[ALIGN_BITS-1:0]` is non-zero.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count equals RAS_DEPTH.
- ras_underflow  out  1  registered one-cycle pulse on `ret` with an empty RAS.
- ras_overflow  out  1  registered one-cycle pulse on `call` with a full RAS.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_VEC, RAS count=0, RAS pointer=0.
  - ras_underflow=0, ras_overflow=0.
  - ras_empty=1, ras_full=0.
  - Reset takes effect immediately, mid-operation included; RAS contents are don't-care.
- ce=0: pc, RAS, count and pointer hold; error pulses clear to 0 on the next edge.
- ce=1: next state on the rising edge, evaluated in priority order:
  1. redirect=1: pc<=target. RAS untouched. Simultaneous call/ret are ignored (a mispredict squashes them).
  2. ret=1 (call is ignored when both are set):
     - RAS non-empty: pc<=top entry; count decrements; pointer moves down.
     - RAS empty: pc<=pc+STEP, ras_underflow<=1, count stays 0.
  3. call=1: pc<=target, and pc+STEP is pushed.
     - RAS full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_overflow<=1.
  4. Otherwise: pc<=pc+STEP.
- Arithmetic:
  - All PC sums wrap modulo 2^ADDR_W; 0xFFFFFFFC+4 gives 0x00000000, with no flag.
  - RAS pointer wraps modulo RAS_DEPTH.
- Latency:
  - A control input sampled at edge N appears on `pc` after edge N.
  - A popped address is available the cycle after a push; no bypass is needed beyond registered storage.
- Error pulses are high for exactly one cycle after the causing edge; otherwise 0.
- misaligned is a status output only; it does not alter PC flow.

Decomposition:
- Package `fetch_pkg`: ADDR_W default, STEP default, RESET_VEC default, and the control-priority encoding as constants.
- One natural sub-module, `ras_stack`: circular LIFO with push/pop/full/empty/overflow and the overwrite-on-full policy.
- `pc_unit` holds the PC register, adder, priority mux and flags.

Test Plan:
- Reset with RESET_VEC=0x100 → pc=0x100, ras_empty=1; after 3 edges with ce=1 and no controls, pc=0x10C; ce=0 for 2 cycles keeps pc=0x10C.
- redirect with target=0x2000 together with call=1 → pc=0x2000, ras_empty stays 1; next edge gives pc=0x2004.
- At pc=0x40, call with target=0x800 → pc=0x800; at pc=0x804, call with target=0xC00 → pc=0xC00; ret → pc=0x808; ret → pc=0x44; ras_empty=1.
- With RAS_DEPTH=4, five calls from pc=0x10,0x20,0x30,0x40,0x50 → ras_overflow pulses once on the 5th; four rets return 0x54,0x44,0x34,0x24.
- ret on an empty RAS at pc=0x60 → pc=0x64, ras_underflow high for one cycle; then assert rst_n=0 mid-sequence → pc returns to RESET_VEC immediately, without a clock edge.
- pc=0xFFFFFFFC with an increment → pc=0x00000000; redirect target=0x1002 → misaligned=1.
